// File: rtl/row_decoder_seq_pkg.sv
// Shared CAM sequencing definitions: wordline FSM states, row-count derivation
// and the default phase lengths also used by the match-line sequencer.
package row_decoder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_WLON,
        ST_FIN
    } row_seq_state_e;

    localparam int DEF_PRE_CYC = 1;
    localparam int DEF_WL_CYC  = 2;

    function automatic int rows_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // One shared phase counter; it must hold the longer phase length minus one.
    function automatic int phase_cnt_w(input int pre_cyc, input int wl_cyc);
        int longest;
        longest = (pre_cyc > wl_cyc) ? pre_cyc : wl_cyc;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/row_decoder_seq_onehot_dec.sv
// Combinational ADDR_W-to-ROWS one-hot decoder with enable; the parent
// registers its output so the wordlines never see decode glitches.
module row_onehot_dec
    import row_decoder_seq_pkg::*;
#(
    parameter int   ADDR_W = 2,
    localparam int  ROWS   = rows_of(ADDR_W)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [ROWS-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/row_decoder_seq.sv
// Handshaked row decoder and wordline sequencer: precharge, then a timed
// wordline pulse on one row or on an ascending sweep of rows.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready for a request while E is high
// ST_PRE  | bitline precharge, PRE_CYC cycles
// ST_WLON | wordline of row_q high, WL_CYC cycles; next row or finish
// ST_FIN  | one-cycle DONE pulse
module row_decoder_seq
    import row_decoder_seq_pkg::*;
#(
    parameter int   ADDR_W  = 2,
    parameter int   PRE_CYC = DEF_PRE_CYC,
    parameter int   WL_CYC  = DEF_WL_CYC,
    localparam int  ROWS    = rows_of(ADDR_W)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              E,
    input  logic              REQ_V,
    output logic              REQ_R,
    input  logic              MODE,
    input  logic [ADDR_W-1:0] ADDR,
    output logic              PRE,
    output logic [ROWS-1:0]   WL,
    output logic [ADDR_W-1:0] ROW_IDX,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CNT_W = phase_cnt_w(PRE_CYC, WL_CYC);
    localparam logic [CNT_W-1:0]  PRE_LOAD = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0]  WL_LOAD  = CNT_W'(WL_CYC - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = '1;

    row_seq_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              mode_q, mode_d;
    logic              pre_q, pre_d;
    logic [ROWS-1:0]   wl_q, wl_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        mode_d  = mode_q;
        // With E low everything holds; the registered outputs below drop to 0.
        if (E) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (REQ_V) begin
                        state_d = ST_PRE;
                        cnt_d   = PRE_LOAD;
                        row_d   = ADDR;
                        mode_d  = MODE;
                    end
                end
                ST_PRE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_WLON;
                        cnt_d   = WL_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_WLON: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (mode_q && (row_q != ROW_LAST)) begin
                        state_d = ST_PRE;
                        cnt_d   = PRE_LOAD;
                        row_d   = row_q + 1'b1;
                    end else begin
                        state_d = ST_FIN;
                        cnt_d   = '0;
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pre_d  = E && (state_d == ST_PRE);
        done_d = E && (state_d == ST_FIN);
        busy_d = (state_d != ST_IDLE);
    end

    row_onehot_dec #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr   (row_d),
        .en     (E && (state_d == ST_WLON)),
        .onehot (wl_d)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            mode_q  <= 1'b0;
            pre_q   <= 1'b0;
            wl_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            pre_q   <= pre_d;
            wl_q    <= wl_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign REQ_R   = E && (state_q == ST_IDLE);
    assign PRE     = pre_q;
    assign WL      = wl_q;
    assign ROW_IDX = row_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_row_decoder_seq.sv
// Two sequencer configurations (2/1/2 and 3/2/1) driven by shared random and
// directed stimulus, compared cycle by cycle against a trace-position model.
module tb_row_decoder_seq;

    logic       CLK;
    logic       RST;
    logic       E;
    logic       REQ_V;
    logic       MODE;
    logic [2:0] ADDR;

    logic       r0_req_r, r0_pre, r0_busy, r0_done;
    logic [3:0] r0_wl;
    logic [1:0] r0_row;
    logic       r1_req_r, r1_pre, r1_busy, r1_done;
    logic [7:0] r1_wl;
    logic [2:0] r1_row;

    row_decoder_seq #(.ADDR_W(2), .PRE_CYC(1), .WL_CYC(2)) dut0 (
        .CLK(CLK), .RST(RST), .E(E), .REQ_V(REQ_V), .REQ_R(r0_req_r),
        .MODE(MODE), .ADDR(ADDR[1:0]), .PRE(r0_pre), .WL(r0_wl),
        .ROW_IDX(r0_row), .BUSY(r0_busy), .DONE(r0_done)
    );

    row_decoder_seq #(.ADDR_W(3), .PRE_CYC(2), .WL_CYC(1)) dut1 (
        .CLK(CLK), .RST(RST), .E(E), .REQ_V(REQ_V), .REQ_R(r1_req_r),
        .MODE(MODE), .ADDR(ADDR), .PRE(r1_pre), .WL(r1_wl),
        .ROW_IDX(r1_row), .BUSY(r1_busy), .DONE(r1_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    bit known = 0;

    // model: each request is a fixed trace of cycles indexed by m_pos
    bit m_act [2];
    int m_pos [2];
    int m_mode[2];
    int m_addr[2];
    int m_row [2];
    int e_pre [2];
    int e_wl  [2];
    int e_done[2];
    int e_busy[2];
    int e_row [2];

    function automatic int pc(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic int wc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int nrows(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_at(input int i, input int pos);
        int seg, n;
        seg = pc(i) + wc(i);
        n = m_mode[i] ? nrows(i) - m_addr[i] : 1;
        e_pre[i] = 0; e_wl[i] = 0; e_done[i] = 0; e_busy[i] = 1;
        if (pos < n * seg) begin
            e_row[i] = m_addr[i] + pos / seg;
            if (pos % seg < pc(i)) e_pre[i] = 1;
            else e_wl[i] = 1 << e_row[i];
        end else if (pos == n * seg) begin
            e_row[i] = m_addr[i] + n - 1;
            e_done[i] = 1;
        end else begin
            e_row[i] = m_addr[i] + n - 1;
            e_busy[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit e, input bit rv,
                              input bit md, input int a);
        e_pre[i] = 0; e_wl[i] = 0; e_done[i] = 0;
        e_busy[i] = m_act[i] ? 1 : 0;
        e_row[i] = m_row[i];
        if (rst) begin
            m_act[i] = 0; m_row[i] = 0;
            e_busy[i] = 0; e_row[i] = 0;
        end else if (!m_act[i]) begin
            if (e && rv) begin
                m_act[i] = 1; m_mode[i] = md; m_addr[i] = a % nrows(i); m_pos[i] = 0;
                model_at(i, 0);
                m_row[i] = e_row[i];
            end
        end else if (e) begin
            m_pos[i]++;
            model_at(i, m_pos[i]);
            m_row[i] = e_row[i];
            if (e_busy[i] == 0) m_act[i] = 0;
        end
    endtask

    task automatic step(input bit rst, input bit e, input bit rv, input bit md, input int a);
        RST = rst; E = e; REQ_V = rv; MODE = md; ADDR = 3'(a);
        #1;
        if (known) begin
            chk("req_r0", 32'(r0_req_r), 32'(e && !m_act[0]));
            chk("req_r1", 32'(r1_req_r), 32'(e && !m_act[1]));
        end
        @(posedge CLK);
        #1;
        known = known | rst;
        for (int i = 0; i < 2; i++) model_step(i, rst, e, rv, md, a);
        if (known) begin
            chk("pre0",  32'(r0_pre),  e_pre[0]);
            chk("wl0",   32'(r0_wl),   e_wl[0]);
            chk("done0", 32'(r0_done), e_done[0]);
            chk("busy0", 32'(r0_busy), e_busy[0]);
            chk("row0",  32'(r0_row),  e_row[0]);
            chk("pre1",  32'(r1_pre),  e_pre[1]);
            chk("wl1",   32'(r1_wl),   e_wl[1]);
            chk("done1", 32'(r1_done), e_done[1]);
            chk("busy1", 32'(r1_busy), e_busy[1]);
            chk("row1",  32'(r1_row),  e_row[1]);
            chk("overlap0", 32'(r0_pre && (r0_wl != '0)), 0);
            chk("overlap1", 32'(r1_pre && (r1_wl != '0)), 0);
            chk("onehot0", 32'($onehot0(r0_wl)), 1);
            chk("onehot1", 32'($onehot0(r1_wl)), 1);
        end
    endtask

    // Accept one request (both units idle), optionally stall E, and report the
    // cycle (1 = first cycle after the accepting edge) in which each DONE rose.
    task automatic run_req(input bit md, input int a, input int stall_at, input int stall_len,
                           output int d0, output int d1);
        bit e;
        d0 = -1; d1 = -1;
        step(0, 1, 1, md, a);
        for (int c = 1; c < 64; c++) begin
            if (r0_done && d0 < 0) d0 = c;
            if (r1_done && d1 < 0) d1 = c;
            if (d0 >= 0 && d1 >= 0) break;
            e = !(c >= stall_at && c < stall_at + stall_len);
            step(0, e, 0, 0, 0);
        end
        step(0, 1, 0, 0, 0);
    endtask

    initial begin
        int d0, d1;
        RST = 1; E = 1; REQ_V = 0; MODE = 0; ADDR = 0;
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        run_req(0, 2, 99, 0, d0, d1);
        chk("lat_single0", d0, 4);
        chk("lat_single1", d1, 4);
        run_req(1, 1, 99, 0, d0, d1);
        chk("lat_sweep_a1_0", d0, 10);
        chk("lat_sweep_a1_1", d1, 22);
        run_req(1, 0, 99, 0, d0, d1);
        chk("lat_full_0", d0, 13);
        chk("lat_full_1", d1, 25);
        run_req(1, 7, 99, 0, d0, d1);
        chk("lat_last_row0", d0, 4);
        chk("lat_last_row1", d1, 4);
        run_req(0, 2, 2, 3, d0, d1);
        chk("lat_stall0", d0, 7);
        chk("lat_stall1", d1, 7);

        // busy handshake: REQ_V stays high with changing ADDR
        for (int k = 0; k < 14; k++) step(0, 1, 1, 0, k);
        // reset in the middle of a sweep, then a normal request
        step(0, 1, 1, 1, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        run_req(0, 1, 99, 0, d0, d1);
        chk("lat_after_rst0", d0, 4);
        chk("lat_after_rst1", d1, 4);

        for (int k = 0; k < 4000; k++) begin
            step(($urandom % 150) == 0, ($urandom % 6) != 0, ($urandom % 3) != 0,
                 1'($urandom), int'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/row_decoder_seq.md
# row_decoder_seq

Registered, parametrised N-to-2^N row decoder and wordline sequencer for the 9T-SRAM CAM array. It replaces the combinational 2-to-4 enable decoder with a handshaked unit. For each accepted request it runs a precharge phase and then a timed wordline pulse on one row, or on a sequence of rows. It sits between the CAM controller (request side) and the array wordline drivers (one-hot side).

## Interface
Parameters:
- ADDR_W, 2: address width; ROWS = 2**ADDR_W wordlines.
- PRE_CYC, 1: precharge phase length in cycles, ≥1.
- WL_CYC, 2: wordline pulse length in cycles, ≥1.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- RST  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high).
- E  in  1  global enable; low = stall.
- REQ_V  in  1  request valid.
- REQ_R  out  1  request ready.
- MODE  in  1  0 = single row, 1 = sweep from ADDR to ROWS-1.
- ADDR  in  ADDR_W  start row.
- PRE  out  1  bitline precharge enable.
- WL  out  ROWS  one-hot wordline enables.
- ROW_IDX  out  ADDR_W  row currently being sequenced.
- BUSY  out  1  high whenever not IDLE.
- DONE  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: REQ_R = E. Accept on REQ_V & REQ_R. Capture ADDR into ROW_IDX and capture MODE. Go to PRE.
  - PRE: PRE = 1 for PRE_CYC cycles, then go to WLON.
  - WLON: WL[ROW_IDX] = 1 for WL_CYC cycles. At the end, if MODE = 1 and ROW_IDX ≠ ROWS-1: ROW_IDX+1, go to PRE. Otherwise go to FIN.
  - FIN: DONE = 1 for one cycle, then go to IDLE.
- Sweep does not wrap. ADDR = 0 with MODE = 1 sweeps all rows. ADDR = ROWS-1 with MODE = 1 behaves as single.
- Inputs are ignored outside IDLE. MODE and ADDR are sampled only at accept.
- Break-before-make: PRE and any WL bit are never high in the same cycle. WL is zero or one-hot, never more than one bit.
- E low in any non-IDLE state:
  - FSM, phase counter and ROW_IDX freeze.
  - PRE, WL and DONE are forced 0 while E is low.
  - On E high the phase resumes with its remaining count.
  - BUSY stays 1.
- A single phase cycle counter, width clog2(max(PRE_CYC, WL_CYC)), reloads on each phase entry.
- RST (any state, including mid-pulse):
  - Next edge: state = IDLE.
  - PRE = 0, WL = 0, DONE = 0, BUSY = 0, ROW_IDX = 0, counter = 0.
  - REQ_R = E after reset.

## Timing
- All outputs are registered. REQ_R is combinational from state and E.
- Accept at edge k (all following ranges assume E held high):
  - PRE high in cycles k+1 … k+PRE_CYC.
  - WL high in the next WL_CYC cycles.
  - DONE high in the following cycle.
  - REQ_R returns the cycle after DONE.
- Single-request latency, accept to DONE, is PRE_CYC + WL_CYC + 1 cycles. A sweep of n rows takes n·(PRE_CYC + WL_CYC) + 1 cycles.
- Back-to-back throughput: one request per PRE_CYC + WL_CYC + 2 cycles.
- E is sampled each cycle. Stall cycles extend latency one-for-one.

## Structure
- Shared CAM package holds:
  - the FSM state enum (IDLE, PRE, WLON, FIN);
  - the ROWS derivation;
  - default phase constants, reused by the match-line sequencer.
- One natural sub-module, row_onehot_dec: a combinational ADDR_W → ROWS decoder with enable, the generalised decoder. Its output is registered in the parent.

## Test plan
Defaults: ADDR_W = 2, PRE_CYC = 1, WL_CYC = 2.
- Single access: REQ_V = 1, MODE = 0, ADDR = 2 at edge 0 → PRE = 1 in cycle 1; WL = 4'b0100 in cycles 2–3; DONE in cycle 4; REQ_R = 1 in cycle 5.
- Sweep: MODE = 1, ADDR = 1 → WL = 0010, then 0100, then 1000, each 2 cycles and each preceded by 1 PRE cycle; DONE at cycle 10; no wrap to 0001.
- Stall: drop E for 3 cycles during the first WL cycle of a single access → WL = 0 during the stall; one WL cycle remains after E rises; DONE is delayed by exactly 3 cycles.
- Reset mid-op: assert RST during WL of a sweep → next cycle WL = 0, PRE = 0, BUSY = 0, ROW_IDX = 0; a new request is accepted normally afterwards.
- Handshake: REQ_V held high with changing ADDR while BUSY → only the first ADDR is used; the second request is accepted the cycle after DONE.
- Parameter sweep: ADDR_W = 3, PRE_CYC = 2, WL_CYC = 1, full sweep → 8 rows × 3 cycles + 1 = 25 cycles; the one-hot and no-PRE/WL-overlap assertions hold throughout.
